// File: rtl/router_fsm.sv
// Packet-write sequencer for the 1x3 router: header decode, drain wait, load/stall/parity phases.
// Optional ROUTER_FSM_ADDR_CHECK_EN adds a DROP_PACKET state that swallows packets addressed to 11.
module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
`ifdef ROUTER_FSM_ADDR_CHECK_EN
    DROP_PACKET        = 4'd8,
`endif
    CHECK_PARITY_ERROR = 4'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;

  logic hdr_ok, hdr_empty, tgt_empty, tgt_soft;
  logic detect_add_d, lfd_state_d, ld_state_d, laf_state_d;
  logic full_state_d, write_enb_reg_d, rst_int_reg_d, busy_d;

  // Header target comes straight off data_in; later phases use the latched address.
  always_comb begin
    hdr_ok    = pkt_valid && (data_in != 2'b11);
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
    tgt_empty = 1'b0;
    tgt_soft  = 1'b0;
    case (addr_q)
      2'd0:    begin tgt_empty = fifo_empty_0; tgt_soft = soft_reset_0; end
      2'd1:    begin tgt_empty = fifo_empty_1; tgt_soft = soft_reset_1; end
      2'd2:    begin tgt_empty = fifo_empty_2; tgt_soft = soft_reset_2; end
      default: begin tgt_empty = 1'b0;         tgt_soft = 1'b0;         end
    endcase
  end

  // Next state plus output decode of the next state, so outputs leave flops.
  always_comb begin
    state_d         = state_q;
    detect_add_d    = 1'b0;
    lfd_state_d     = 1'b0;
    ld_state_d      = 1'b0;
    laf_state_d     = 1'b0;
    full_state_d    = 1'b0;
    write_enb_reg_d = 1'b0;
    rst_int_reg_d   = 1'b0;
    busy_d          = 1'b0;

    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok && hdr_empty)  state_d = LOAD_FIRST_DATA;
        else if (hdr_ok)          state_d = WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
        else if (pkt_valid)       state_d = DROP_PACKET;
`endif
      end
      WAIT_TILL_EMPTY:    if (tgt_empty) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_d = DECODE_ADDRESS;
        else if (low_packet_valid) state_d = LOAD_PARITY;
        else                       state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
      DROP_PACKET:        if (!pkt_valid) state_d = DECODE_ADDRESS;
`endif
      default:            state_d = DECODE_ADDRESS;
    endcase

    // Read-timeout soft reset of the addressed FIFO aborts the packet.
    if (state_q != DECODE_ADDRESS && tgt_soft) state_d = DECODE_ADDRESS;

    case (state_d)
      DECODE_ADDRESS:     detect_add_d = 1'b1;
      WAIT_TILL_EMPTY:    busy_d = 1'b1;
      LOAD_FIRST_DATA:    begin lfd_state_d = 1'b1; busy_d = 1'b1; end
      LOAD_DATA:          begin ld_state_d = 1'b1; write_enb_reg_d = 1'b1; end
      FIFO_FULL_STATE:    begin full_state_d = 1'b1; busy_d = 1'b1; end
      LOAD_AFTER_FULL:    begin laf_state_d = 1'b1; busy_d = 1'b1; write_enb_reg_d = 1'b1; end
      LOAD_PARITY:        begin busy_d = 1'b1; write_enb_reg_d = 1'b1; end
      CHECK_PARITY_ERROR: begin rst_int_reg_d = 1'b1; busy_d = 1'b1; end
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= DECODE_ADDRESS;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (state_q == DECODE_ADDRESS && pkt_valid) addr_q <= ADDR_W'(data_in);
      detect_add    <= detect_add_d;
      lfd_state     <= lfd_state_d;
      ld_state      <= ld_state_d;
      laf_state     <= laf_state_d;
      full_state    <= full_state_d;
      write_enb_reg <= write_enb_reg_d;
      rst_int_reg   <= rst_int_reg_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm; output vector is {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] S_DEC  = 8'b1000_0000;
  localparam logic [7:0] S_WAIT = 8'b0000_0001;
  localparam logic [7:0] S_LFD  = 8'b0100_0001;
  localparam logic [7:0] S_LD   = 8'b0010_0100;
  localparam logic [7:0] S_LAF  = 8'b0001_0101;
  localparam logic [7:0] S_FULL = 8'b0000_1001;
  localparam logic [7:0] S_LP   = 8'b0000_0101;
  localparam logic [7:0] S_CHK  = 8'b0000_0011;
  localparam logic [7:0] S_DROP = 8'b0000_0000;

  logic [7:0] obs;
  assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};

  router_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;
    #12;
    checks++;
    if (obs !== S_DEC) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, S_DEC); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== S_DEC) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs, S_DEC); end
  endtask

  task automatic test_basic_packet();
    logic       pv  [7];
    logic [7:0] exp [7];
    int we_cnt = 0, ri_cnt = 0;
    pv  = '{1, 1, 1, 1, 0, 0, 0};
    exp = '{S_LFD, S_LD, S_LD, S_LD, S_LP, S_CHK, S_DEC};
    data_in = 2'b01;
    for (int i = 0; i < 7; i++) begin
      pkt_valid = pv[i];
      @(posedge clk); #1;
      if (write_enb_reg) we_cnt++;
      if (rst_int_reg) ri_cnt++;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL basic_step%0d got=%b exp=%b", i, obs, exp[i]); end
      data_in = 2'b10;
    end
    data_in = 2'b00;
    checks++;
    if (we_cnt !== 4) begin errors++; $display("FAIL basic_write_cycles got=%0d exp=4", we_cnt); end
    checks++;
    if (ri_cnt !== 1) begin errors++; $display("FAIL basic_rst_int_pulses got=%0d exp=1", ri_cnt); end
  endtask

  task automatic test_wait_empty();
    logic [7:0] exp [8];
    exp = '{S_WAIT, S_WAIT, S_WAIT, S_WAIT, S_LFD, S_LD, S_LP, S_CHK};
    fifo_empty_2 = 1'b0;
    pkt_valid = 1'b1; data_in = 2'b10;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) data_in = 2'b00;
      if (i == 4) fifo_empty_2 = 1'b1;
      if (i == 5) pkt_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL wait_step%0d got=%b exp=%b", i, obs, exp[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== S_DEC) begin errors++; $display("FAIL wait_return got=%b exp=%b", obs, S_DEC); end
  endtask

  task automatic test_full_stall();
    logic       pv  [11];
    logic       ff  [11];
    logic       lpv [11];
    logic       pd  [11];
    logic [7:0] exp [11];
    pv  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ff  = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    lpv = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    pd  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    exp = '{S_LFD, S_LD, S_FULL, S_FULL, S_LAF, S_LP, S_CHK, S_FULL, S_LAF, S_DEC, S_DEC};
    data_in = 2'b00;
    for (int i = 0; i < 11; i++) begin
      pkt_valid = pv[i]; fifo_full = ff[i]; low_packet_valid = lpv[i]; parity_done = pd[i];
      @(posedge clk); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL full_step%0d got=%b exp=%b", i, obs, exp[i]); end
    end
  endtask

  task automatic test_laf_to_load();
    logic       pv  [8];
    logic       ff  [8];
    logic [7:0] exp [8];
    pv  = '{1, 1, 1, 1, 1, 0, 0, 0};
    ff  = '{0, 0, 1, 0, 0, 0, 0, 0};
    exp = '{S_LFD, S_LD, S_FULL, S_LAF, S_LD, S_LP, S_CHK, S_DEC};
    data_in = 2'b01;
    for (int i = 0; i < 8; i++) begin
      pkt_valid = pv[i]; fifo_full = ff[i];
      @(posedge clk); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL laf_step%0d got=%b exp=%b", i, obs, exp[i]); end
    end
    data_in = 2'b00;
  endtask

  task automatic test_soft_reset();
    logic [7:0] exp [5];
    exp = '{S_WAIT, S_WAIT, S_WAIT, S_DEC, S_DEC};
    fifo_empty_0 = 1'b0; pkt_valid = 1'b1; data_in = 2'b00;
    for (int i = 0; i < 5; i++) begin
      soft_reset_1 = (i == 2);
      soft_reset_0 = (i == 3);
      if (i == 4) begin pkt_valid = 1'b0; fifo_empty_0 = 1'b1; end
      @(posedge clk); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL soft_step%0d got=%b exp=%b", i, obs, exp[i]); end
    end
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] exp [5];
    pkt_valid = 1'b1; data_in = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (obs !== S_LD) begin errors++; $display("FAIL arst_pre got=%b exp=%b", obs, S_LD); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== S_DEC) begin errors++; $display("FAIL arst_immediate got=%b exp=%b", obs, S_DEC); end
    @(negedge clk); rst = 1'b1; data_in = 2'b01;
    exp = '{S_LFD, S_LD, S_LP, S_CHK, S_DEC};
    for (int i = 0; i < 5; i++) begin
      if (i == 1) pkt_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL arst_after_step%0d got=%b exp=%b", i, obs, exp[i]); end
    end
    data_in = 2'b00;
  endtask

  task automatic test_addr3();
    logic [7:0] exp [5];
    int we_cnt = 0;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
    exp = '{S_DROP, S_DROP, S_DROP, S_DEC, S_DEC};
`else
    exp = '{S_DEC, S_DEC, S_DEC, S_DEC, S_DEC};
`endif
    data_in = 2'b11; pkt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) pkt_valid = 1'b0;
      @(posedge clk); #1;
      if (write_enb_reg) we_cnt++;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL addr3_step%0d got=%b exp=%b", i, obs, exp[i]); end
    end
    checks++;
    if (we_cnt !== 0) begin errors++; $display("FAIL addr3_no_write got=%0d exp=0", we_cnt); end
    data_in = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_full_stall();
    test_laf_to_load();
    test_soft_reset();
    test_async_reset();
    test_addr3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
